rename_multi: RTL and testbench
===============================

# rename_multi

Multi-lane register-rename stage with branch checkpoints. Each cycle it renames a bundle of up to LANES decoded instructions, resolving intra-bundle dependencies. It contains the architectural-to-physical map table, a circular free list, a ROB-tag counter and a FIFO of branch checkpoints that supports recovery to any unresolved branch. It sits between decode and dispatch/issue and receives frees from ROB commit.

## Interface
- AREG_WIDTH, 5, architectural register index width (NUM_AREG = 2^AREG_WIDTH)
- PREG_WIDTH, 7, physical register index width (NUM_PREG = 2^PREG_WIDTH)
- ROB_WIDTH, 4, ROB tag width
- LANES, 2, instructions per bundle (1..4)
- CKPT_WIDTH, 2, checkpoint id width (NUM_CKPT = 2^CKPT_WIDTH)
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- decode_valid  in  LANES  per-lane valid; contiguous from lane 0
- decode_rs1, decode_rs2, decode_rd  in  LANES*AREG_WIDTH  per-lane arch regs, lane i at [i*AREG_WIDTH +: AREG_WIDTH]
- decode_reg_write  in  LANES  lane writes rd
- decode_is_branch  in  LANES  lane is a branch; at most one per bundle
- i_ready  in  1  dispatch can accept a bundle
- rename_ready  out  1  bundle accepted this cycle if any decode_valid
- dispatch_valid  out  LANES
- dispatch_prs1, dispatch_prs2, dispatch_prd, dispatch_old_prd  out  LANES*PREG_WIDTH
- dispatch_rob_tag  out  LANES*ROB_WIDTH
- dispatch_ckpt_id  out  CKPT_WIDTH  checkpoint of the bundle's branch
- commit_en  in  LANES;  commit_old_preg  in  LANES*PREG_WIDTH  registers to free
- branch_resolve  in  1  oldest checkpointed branch resolved correctly
- branch_mispredict  in  1;  mispredict_ckpt_id  in  CKPT_WIDTH
- free_count  out  PREG_WIDTH+1  free physical registers

## Operation
- Reset: map[a] = a; free list holds pregs NUM_AREG..NUM_PREG-1 in ascending order (head 0, tail NUM_PREG-NUM_AREG); ROB tag counter 0; checkpoint FIFO empty; free_count = 96 at defaults.
- Free list: ring of NUM_PREG entries; head/tail pointers PREG_WIDTH+1 bits with wrap bit; count = tail - head; never overflows.
- Writing lane: decode_valid && decode_reg_write && rd != 0. Writing lane k takes fl[head + (number of earlier writing lanes)]. Non-writing lanes: dispatch_prd = 0 and dispatch_old_prd = 0.
- Acceptance: rename_ready = i_ready && !branch_mispredict && free_count >= writing-lane count && (no branch in bundle || checkpoint FIFO not full). All-or-nothing: dispatch_valid = decode_valid when rename_ready, else 0.
- Sources: prs of lane j = new preg of the youngest earlier writing lane with matching rd, else map[rs]. rs = 0 always gives preg 0. dispatch_old_prd uses the same bypass on rd.
- ROB tags: lane i tag = counter + i; counter += valid-lane count on accept, wrapping mod 2^ROB_WIDTH.
- Checkpoint on an accepted branch lane b: store map after lanes 0..b, free-list head after lanes 0..b, and ROB counter + b + 1. Push at FIFO tail; dispatch_ckpt_id = tail id.
- branch_resolve pops the FIFO head.
- branch_mispredict: restore map, head and ROB counter from mispredict_ckpt_id. Set FIFO tail = id + 1 (the entry stays valid until its resolve). No rename that cycle.
- Commit: for each lane with commit_en and old_preg != 0, write fl[tail] in lane order and advance tail. Always processed, including during mispredict.
- Illegal, not checked: branch_resolve together with branch_mispredict; resolve on an empty FIFO.

## Timing
- Rename outputs are combinational from current state and decode inputs; zero-cycle latency.
- Map, free list, counters and checkpoints update on the rising clk edge after acceptance.
- free_count reflects allocations and frees of the previous edge. Frees are not usable in the same cycle they arrive.
- Recovery takes effect at the edge; the bundle in the following cycle sees the restored map.
- Reset mid-operation discards all checkpoints and in-flight allocations. Outputs follow the reset state the next cycle.

## Test plan
- Reset; lanes rd=1 rs1=3 and rd=2 rs1=4 -> prd 32, 33; old_prd 1, 2; prs1 3, 4; rob_tag 0, 1; free_count 94.
- Lane0 rd=5, lane1 rs1=5 rs2=5 rd=5 -> lane1 prs1 = prs2 = 32, old_prd 32, prd 33; next cycle map[5] = 33.
- Allocate until free_count = 1; two-writer bundle -> rename_ready 0, dispatch_valid 00. One-writer bundle is accepted.
- Branch in lane0, lane1 rd=7 -> checkpoint 0. Later bundles rename x7 again. Mispredict id 0 -> map[7] restored to 7, head and ROB tag rewound, lane1 preg reallocated.
- Fill NUM_CKPT checkpoints; next branch bundle stalls. branch_resolve -> the bundle is accepted the next cycle.
- Commit old_preg 40 and 0 on both lanes -> free_count +1 only; drive commit across the ring end to exercise pointer wrap.

Source files
------------

// File: rtl/rename_multi_if.sv
// Bundle interface of the rename stage: decode in, dispatch out, commit frees and
// branch recovery controls. The design side uses the slave modport.
interface rename_multi_if #(
    parameter int AREG_WIDTH = 5,
    parameter int PREG_WIDTH = 7,
    parameter int ROB_WIDTH  = 4,
    parameter int LANES      = 2,
    parameter int CKPT_WIDTH = 2
);
    logic [LANES-1:0]            decode_valid;
    logic [LANES*AREG_WIDTH-1:0] decode_rs1;
    logic [LANES*AREG_WIDTH-1:0] decode_rs2;
    logic [LANES*AREG_WIDTH-1:0] decode_rd;
    logic [LANES-1:0]            decode_reg_write;
    logic [LANES-1:0]            decode_is_branch;
    logic                        i_ready;
    logic                        rename_ready;
    logic [LANES-1:0]            dispatch_valid;
    logic [LANES*PREG_WIDTH-1:0] dispatch_prs1;
    logic [LANES*PREG_WIDTH-1:0] dispatch_prs2;
    logic [LANES*PREG_WIDTH-1:0] dispatch_prd;
    logic [LANES*PREG_WIDTH-1:0] dispatch_old_prd;
    logic [LANES*ROB_WIDTH-1:0]  dispatch_rob_tag;
    logic [CKPT_WIDTH-1:0]       dispatch_ckpt_id;
    logic [LANES-1:0]            commit_en;
    logic [LANES*PREG_WIDTH-1:0] commit_old_preg;
    logic                        branch_resolve;
    logic                        branch_mispredict;
    logic [CKPT_WIDTH-1:0]       mispredict_ckpt_id;
    logic [PREG_WIDTH:0]         free_count;

    modport master (
        output decode_valid, decode_rs1, decode_rs2, decode_rd, decode_reg_write,
               decode_is_branch, i_ready, commit_en, commit_old_preg,
               branch_resolve, branch_mispredict, mispredict_ckpt_id,
        input  rename_ready, dispatch_valid, dispatch_prs1, dispatch_prs2, dispatch_prd,
               dispatch_old_prd, dispatch_rob_tag, dispatch_ckpt_id, free_count
    );

    modport slave (
        input  decode_valid, decode_rs1, decode_rs2, decode_rd, decode_reg_write,
               decode_is_branch, i_ready, commit_en, commit_old_preg,
               branch_resolve, branch_mispredict, mispredict_ckpt_id,
        output rename_ready, dispatch_valid, dispatch_prs1, dispatch_prs2, dispatch_prd,
               dispatch_old_prd, dispatch_rob_tag, dispatch_ckpt_id, free_count
    );
endinterface

// File: rtl/rename_multi.sv
// Multi-lane register rename: map table, circular free list, ROB tag counter and a
// FIFO of branch checkpoints with recovery to any unresolved branch.
module rename_multi #(
    parameter int AREG_WIDTH = 5,
    parameter int PREG_WIDTH = 7,
    parameter int ROB_WIDTH  = 4,
    parameter int LANES      = 2,
    parameter int CKPT_WIDTH = 2
) (
    input  logic          clk,
    input  logic          reset,
    rename_multi_if.slave rn
);
    localparam int NUM_AREG = 1 << AREG_WIDTH;
    localparam int NUM_PREG = 1 << PREG_WIDTH;
    localparam int NUM_CKPT = 1 << CKPT_WIDTH;

    typedef logic [PREG_WIDTH-1:0]               preg_t;
    typedef logic [PREG_WIDTH:0]                 fptr_t;
    typedef logic [ROB_WIDTH-1:0]                rob_t;
    typedef logic [NUM_AREG-1:0][PREG_WIDTH-1:0] map_t;

    map_t                  map_r;
    preg_t                 fl_r [NUM_PREG];
    fptr_t                 head_r;
    fptr_t                 tail_r;
    rob_t                  rob_r;
    map_t                  ckpt_map_r  [NUM_CKPT];
    fptr_t                 ckpt_head_r [NUM_CKPT];
    rob_t                  ckpt_rob_r  [NUM_CKPT];
    logic [CKPT_WIDTH-1:0] ckpt_rd_ptr_r;
    logic [CKPT_WIDTH-1:0] ckpt_wr_ptr_r;
    logic [CKPT_WIDTH:0]   ckpt_cnt_r;

    map_t                        next_map_s;
    map_t                        ckpt_map_s;
    fptr_t                       n_write_s;
    fptr_t                       ckpt_head_s;
    fptr_t                       free_count_s;
    fptr_t                       n_free_s;
    rob_t                        n_valid_s;
    rob_t                        ckpt_rob_s;
    logic                        has_branch_s;
    logic                        ckpt_full_s;
    logic                        rename_ready_s;
    logic                        accept_s;
    logic                        push_s;
    logic [LANES-1:0]            commit_we_s;
    preg_t                       commit_idx_s [LANES];
    logic [LANES*PREG_WIDTH-1:0] prs1_s;
    logic [LANES*PREG_WIDTH-1:0] prs2_s;
    logic [LANES*PREG_WIDTH-1:0] prd_s;
    logic [LANES*PREG_WIDTH-1:0] old_prd_s;
    logic [LANES*ROB_WIDTH-1:0]  rob_tag_s;

    assign free_count_s   = tail_r - head_r;
    assign ckpt_full_s    = (ckpt_cnt_r == (CKPT_WIDTH+1)'(NUM_CKPT));
    assign rename_ready_s = rn.i_ready && !rn.branch_mispredict && (free_count_s >= n_write_s)
                            && (!has_branch_s || !ckpt_full_s);
    assign accept_s       = rename_ready_s && (|rn.decode_valid);
    assign push_s         = accept_s && has_branch_s;

    // Lanes walk in order over a running copy of the map, so later lanes see earlier writers.
    always_comb begin
        logic [AREG_WIDTH-1:0] rs1;
        logic [AREG_WIDTH-1:0] rs2;
        logic [AREG_WIDTH-1:0] rd;
        preg_t                 new_preg;
        logic                  wr;
        logic                  br;
        rs1          = '0;
        rs2          = '0;
        rd           = '0;
        new_preg     = '0;
        wr           = 1'b0;
        br           = 1'b0;
        next_map_s   = map_r;
        n_write_s    = '0;
        n_valid_s    = '0;
        has_branch_s = 1'b0;
        ckpt_map_s   = map_r;
        ckpt_head_s  = head_r;
        ckpt_rob_s   = rob_r;
        prs1_s       = '0;
        prs2_s       = '0;
        prd_s        = '0;
        old_prd_s    = '0;
        rob_tag_s    = '0;
        for (int i = 0; i < LANES; i++) begin
            rs1      = rn.decode_rs1[i*AREG_WIDTH +: AREG_WIDTH];
            rs2      = rn.decode_rs2[i*AREG_WIDTH +: AREG_WIDTH];
            rd       = rn.decode_rd[i*AREG_WIDTH +: AREG_WIDTH];
            wr       = rn.decode_valid[i] && rn.decode_reg_write[i] && (rd != '0);
            br       = rn.decode_valid[i] && rn.decode_is_branch[i];
            new_preg = fl_r[head_r[PREG_WIDTH-1:0] + n_write_s[PREG_WIDTH-1:0]];
            prs1_s[i*PREG_WIDTH +: PREG_WIDTH] = (rs1 == '0) ? '0 : next_map_s[rs1];
            prs2_s[i*PREG_WIDTH +: PREG_WIDTH] = (rs2 == '0) ? '0 : next_map_s[rs2];
            rob_tag_s[i*ROB_WIDTH +: ROB_WIDTH] = rob_r + rob_t'(i);
            if (wr) begin
                old_prd_s[i*PREG_WIDTH +: PREG_WIDTH] = next_map_s[rd];
                prd_s[i*PREG_WIDTH +: PREG_WIDTH]     = new_preg;
                next_map_s[rd]                        = new_preg;
                n_write_s                             = n_write_s + fptr_t'(1);
            end else begin
                old_prd_s[i*PREG_WIDTH +: PREG_WIDTH] = '0;
                prd_s[i*PREG_WIDTH +: PREG_WIDTH]     = '0;
            end
            n_valid_s    = n_valid_s + rob_t'(rn.decode_valid[i]);
            has_branch_s = has_branch_s | br;
            ckpt_map_s   = br ? next_map_s : ckpt_map_s;
            ckpt_head_s  = br ? (head_r + n_write_s) : ckpt_head_s;
            ckpt_rob_s   = br ? (rob_r + rob_t'(i + 1)) : ckpt_rob_s;
        end
    end

    // Commit frees land at consecutive tail slots in lane order.
    always_comb begin
        n_free_s    = '0;
        commit_we_s = '0;
        for (int i = 0; i < LANES; i++) begin
            commit_idx_s[i] = tail_r[PREG_WIDTH-1:0] + n_free_s[PREG_WIDTH-1:0];
            commit_we_s[i]  = rn.commit_en[i]
                              && (rn.commit_old_preg[i*PREG_WIDTH +: PREG_WIDTH] != '0);
            n_free_s        = n_free_s + fptr_t'(commit_we_s[i]);
        end
    end

    assign rn.rename_ready     = rename_ready_s;
    assign rn.dispatch_valid   = rename_ready_s ? rn.decode_valid : '0;
    assign rn.dispatch_prs1    = prs1_s;
    assign rn.dispatch_prs2    = prs2_s;
    assign rn.dispatch_prd     = prd_s;
    assign rn.dispatch_old_prd = old_prd_s;
    assign rn.dispatch_rob_tag = rob_tag_s;
    assign rn.dispatch_ckpt_id = ckpt_wr_ptr_r;
    assign rn.free_count       = free_count_s;

    // Free-list storage: initial contents are the pregs not mapped at reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_PREG; i++) begin
                fl_r[i] <= (i < NUM_PREG - NUM_AREG) ? preg_t'(i + NUM_AREG) : '0;
            end
        end else begin
            for (int i = 0; i < LANES; i++) begin
                if (commit_we_s[i]) begin
                    fl_r[commit_idx_s[i]] <= rn.commit_old_preg[i*PREG_WIDTH +: PREG_WIDTH];
                end
            end
        end
    end

    // Map, pointers, ROB counter and checkpoint FIFO control; mispredict overrides renaming.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int a = 0; a < NUM_AREG; a++) begin
                map_r[a] <= preg_t'(a);
            end
            head_r        <= '0;
            tail_r        <= fptr_t'(NUM_PREG - NUM_AREG);
            rob_r         <= '0;
            ckpt_rd_ptr_r <= '0;
            ckpt_wr_ptr_r <= '0;
            ckpt_cnt_r    <= '0;
        end else begin
            tail_r <= tail_r + n_free_s;
            if (rn.branch_mispredict) begin
                map_r         <= ckpt_map_r[rn.mispredict_ckpt_id];
                head_r        <= ckpt_head_r[rn.mispredict_ckpt_id];
                rob_r         <= ckpt_rob_r[rn.mispredict_ckpt_id];
                ckpt_wr_ptr_r <= rn.mispredict_ckpt_id + CKPT_WIDTH'(1);
                ckpt_cnt_r    <= {1'b0, rn.mispredict_ckpt_id - ckpt_rd_ptr_r}
                                 + (CKPT_WIDTH+1)'(1);
            end else begin
                if (accept_s) begin
                    map_r  <= next_map_s;
                    head_r <= head_r + n_write_s;
                    rob_r  <= rob_r + n_valid_s;
                end
                if (rn.branch_resolve) begin
                    ckpt_rd_ptr_r <= ckpt_rd_ptr_r + CKPT_WIDTH'(1);
                end
                if (push_s) begin
                    ckpt_wr_ptr_r <= ckpt_wr_ptr_r + CKPT_WIDTH'(1);
                end
                ckpt_cnt_r <= ckpt_cnt_r + (CKPT_WIDTH+1)'(push_s)
                              - (CKPT_WIDTH+1)'(rn.branch_resolve);
            end
        end
    end

    // Checkpoint payload captured at the FIFO tail when a branch bundle is accepted.
    always_ff @(posedge clk) begin
        if (push_s) begin
            ckpt_map_r[ckpt_wr_ptr_r]  <= ckpt_map_s;
            ckpt_head_r[ckpt_wr_ptr_r] <= ckpt_head_s;
            ckpt_rob_r[ckpt_wr_ptr_r]  <= ckpt_rob_s;
        end
    end
endmodule

// File: tb/tb_rename_multi.sv
// Directed bench for rename_multi: bypassing, stalls, free-list wrap, checkpoints
// and recovery, with hand-computed expected values.
module tb_rename_multi;
    localparam int AW = 5;
    localparam int PW = 7;
    localparam int RW = 4;
    localparam int LN = 2;
    localparam int CW = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    rename_multi_if #(.AREG_WIDTH(AW), .PREG_WIDTH(PW), .ROB_WIDTH(RW), .LANES(LN),
                      .CKPT_WIDTH(CW)) rif ();

    rename_multi #(.AREG_WIDTH(AW), .PREG_WIDTH(PW), .ROB_WIDTH(RW), .LANES(LN),
                   .CKPT_WIDTH(CW)) dut (.clk(clk), .reset(reset), .rn(rif));

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rif.decode_valid       = '0;
        rif.decode_rs1         = '0;
        rif.decode_rs2         = '0;
        rif.decode_rd          = '0;
        rif.decode_reg_write   = '0;
        rif.decode_is_branch   = '0;
        rif.i_ready            = 1'b1;
        rif.commit_en          = '0;
        rif.commit_old_preg    = '0;
        rif.branch_resolve     = 1'b0;
        rif.branch_mispredict  = 1'b0;
        rif.mispredict_ckpt_id = '0;
    endtask

    task automatic lane(input int l, input int rd, input int rs1, input int rs2,
                        input bit wr, input bit br);
        rif.decode_valid[l]           = 1'b1;
        rif.decode_rd[l*AW +: AW]     = AW'(rd);
        rif.decode_rs1[l*AW +: AW]    = AW'(rs1);
        rif.decode_rs2[l*AW +: AW]    = AW'(rs2);
        rif.decode_reg_write[l]       = wr;
        rif.decode_is_branch[l]       = br;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    function automatic int prs1_of(input int l); return int'(rif.dispatch_prs1[l*PW +: PW]); endfunction
    function automatic int prs2_of(input int l); return int'(rif.dispatch_prs2[l*PW +: PW]); endfunction
    function automatic int prd_of(input int l);  return int'(rif.dispatch_prd[l*PW +: PW]); endfunction
    function automatic int old_of(input int l);  return int'(rif.dispatch_old_prd[l*PW +: PW]); endfunction
    function automatic int tag_of(input int l);  return int'(rif.dispatch_rob_tag[l*RW +: RW]); endfunction

    initial begin
        idle();
        tick();
        tick();
        check_eq("rst_free_count", rif.free_count, 96);
        reset = 1'b0;

        // Two independent writers straight after reset
        lane(0, 1, 3, 0, 1'b1, 1'b0);
        lane(1, 2, 4, 0, 1'b1, 1'b0);
        #1;
        check_eq("t1_ready", rif.rename_ready, 1);
        check_eq("t1_valid", rif.dispatch_valid, 3);
        check_eq("t1_prd0", prd_of(0), 32);
        check_eq("t1_prd1", prd_of(1), 33);
        check_eq("t1_old0", old_of(0), 1);
        check_eq("t1_old1", old_of(1), 2);
        check_eq("t1_prs1_0", prs1_of(0), 3);
        check_eq("t1_prs1_1", prs1_of(1), 4);
        check_eq("t1_tag0", tag_of(0), 0);
        check_eq("t1_tag1", tag_of(1), 1);
        tick();
        idle();
        #1;
        check_eq("t1_free_count", rif.free_count, 94);

        // Intra-bundle bypass
        do_reset();
        lane(0, 5, 0, 0, 1'b1, 1'b0);
        lane(1, 5, 5, 5, 1'b1, 1'b0);
        #1;
        check_eq("byp_prs1_0_x0", prs1_of(0), 0);
        check_eq("byp_prd0", prd_of(0), 32);
        check_eq("byp_old0", old_of(0), 5);
        check_eq("byp_prs1_1", prs1_of(1), 32);
        check_eq("byp_prs2_1", prs2_of(1), 32);
        check_eq("byp_old1", old_of(1), 32);
        check_eq("byp_prd1", prd_of(1), 33);
        tick();
        idle();
        lane(0, 0, 5, 5, 1'b0, 1'b0);
        lane(1, 0, 0, 0, 1'b1, 1'b0);
        #1;
        check_eq("map5_prs1", prs1_of(0), 33);
        check_eq("map5_prs2", prs2_of(0), 33);
        check_eq("rd0_prd", prd_of(1), 0);
        check_eq("rd0_old", old_of(1), 0);
        check_eq("map5_valid", rif.dispatch_valid, 3);
        check_eq("map5_tag0", tag_of(0), 2);
        check_eq("map5_tag1", tag_of(1), 3);
        tick();

        // Exhaust the free list down to one register
        for (int k = 0; k < 46; k++) begin
            idle();
            lane(0, 10, 0, 0, 1'b1, 1'b0);
            lane(1, 11, 0, 0, 1'b1, 1'b0);
            tick();
        end
        idle();
        lane(0, 12, 0, 0, 1'b1, 1'b0);
        tick();
        idle();
        #1;
        check_eq("low_free_count", rif.free_count, 1);
        lane(0, 13, 0, 0, 1'b1, 1'b0);
        lane(1, 14, 0, 0, 1'b1, 1'b0);
        #1;
        check_eq("low_stall_ready", rif.rename_ready, 0);
        check_eq("low_stall_valid", rif.dispatch_valid, 0);
        tick();
        idle();
        lane(0, 3, 0, 0, 1'b1, 1'b0);
        lane(1, 0, 3, 0, 1'b0, 1'b0);
        #1;
        check_eq("low_one_ready", rif.rename_ready, 1);
        check_eq("low_one_valid", rif.dispatch_valid, 3);
        check_eq("low_one_prd", prd_of(0), 127);
        check_eq("low_one_byp", prs1_of(1), 127);
        tick();

        // Frees arriving this cycle cannot be used this cycle; zero old_preg is ignored
        idle();
        lane(0, 4, 0, 0, 1'b1, 1'b0);
        rif.commit_en = 2'b11;
        rif.commit_old_preg[0 +: PW]  = 7'd40;
        rif.commit_old_preg[PW +: PW] = 7'd0;
        #1;
        check_eq("empty_ready", rif.rename_ready, 0);
        tick();
        idle();
        #1;
        check_eq("commit_plus1", rif.free_count, 1);
        for (int k = 0; k < 16; k++) begin
            idle();
            rif.commit_en = 2'b11;
            rif.commit_old_preg[0 +: PW]  = PW'(64 + 2 * k);
            rif.commit_old_preg[PW +: PW] = PW'(65 + 2 * k);
            tick();
        end
        idle();
        #1;
        check_eq("wrap_free_count", rif.free_count, 33);
        lane(0, 20, 0, 0, 1'b1, 1'b0);
        lane(1, 21, 0, 0, 1'b1, 1'b0);
        #1;
        check_eq("wrap_prd0", prd_of(0), 40);
        check_eq("wrap_prd1", prd_of(1), 64);
        tick();
        for (int k = 0; k < 14; k++) begin
            idle();
            lane(0, 20, 0, 0, 1'b1, 1'b0);
            lane(1, 21, 0, 0, 1'b1, 1'b0);
            tick();
        end
        idle();
        lane(0, 20, 0, 0, 1'b1, 1'b0);
        lane(1, 21, 0, 0, 1'b1, 1'b0);
        #1;
        check_eq("ring_end_prd0", prd_of(0), 93);
        check_eq("ring_end_prd1", prd_of(1), 94);
        tick();
        idle();
        lane(0, 22, 0, 0, 1'b1, 1'b0);
        #1;
        check_eq("ring_wrap_ready", rif.rename_ready, 1);
        check_eq("ring_wrap_prd", prd_of(0), 95);
        tick();
        idle();
        #1;
        check_eq("ring_drained", rif.free_count, 0);

        // Checkpoint and mispredict to id 0
        do_reset();
        lane(0, 0, 0, 0, 1'b0, 1'b1);
        lane(1, 7, 7, 0, 1'b1, 1'b0);
        #1;
        check_eq("b1_ready", rif.rename_ready, 1);
        check_eq("b1_ckpt", rif.dispatch_ckpt_id, 0);
        check_eq("b1_prd1", prd_of(1), 32);
        check_eq("b1_old1", old_of(1), 7);
        check_eq("b1_tag1", tag_of(1), 1);
        tick();
        idle();
        lane(0, 7, 7, 0, 1'b1, 1'b0);
        lane(1, 7, 7, 0, 1'b1, 1'b0);
        #1;
        check_eq("b2_prs1_0", prs1_of(0), 32);
        check_eq("b2_prd0", prd_of(0), 33);
        check_eq("b2_prs1_1", prs1_of(1), 33);
        check_eq("b2_old1", old_of(1), 33);
        check_eq("b2_prd1", prd_of(1), 34);
        tick();
        idle();
        lane(0, 7, 7, 0, 1'b1, 1'b0);
        rif.branch_mispredict  = 1'b1;
        rif.mispredict_ckpt_id = 2'd0;
        #1;
        check_eq("mp_ready", rif.rename_ready, 0);
        check_eq("mp_valid", rif.dispatch_valid, 0);
        tick();
        idle();
        #1;
        check_eq("mp_free_count", rif.free_count, 96);
        lane(0, 7, 7, 0, 1'b1, 1'b0);
        #1;
        check_eq("mp_map7", prs1_of(0), 7);
        check_eq("mp_realloc", prd_of(0), 32);
        check_eq("mp_old", old_of(0), 7);
        check_eq("mp_tag", tag_of(0), 1);
        tick();

        // Fill the checkpoint FIFO
        idle();
        lane(0, 0, 0, 0, 1'b0, 1'b1);
        #1;
        check_eq("f1_ckpt", rif.dispatch_ckpt_id, 1);
        check_eq("f1_tag", tag_of(0), 2);
        tick();
        idle();
        lane(0, 0, 0, 0, 1'b0, 1'b1);
        lane(1, 8, 8, 0, 1'b1, 1'b0);
        #1;
        check_eq("f2_ckpt", rif.dispatch_ckpt_id, 2);
        check_eq("f2_prd1", prd_of(1), 33);
        check_eq("f2_tag", tag_of(0), 3);
        tick();
        idle();
        lane(0, 0, 0, 0, 1'b0, 1'b1);
        #1;
        check_eq("f3_ckpt", rif.dispatch_ckpt_id, 3);
        check_eq("f3_ready", rif.rename_ready, 1);
        tick();
        idle();
        lane(0, 0, 0, 0, 1'b0, 1'b1);
        #1;
        check_eq("full_ready", rif.rename_ready, 0);
        check_eq("full_valid", rif.dispatch_valid, 0);
        idle();
        lane(0, 0, 0, 0, 1'b0, 1'b0);
        #1;
        check_eq("full_nobr_ready", rif.rename_ready, 1);
        check_eq("full_nobr_tag", tag_of(0), 6);
        tick();
        idle();
        lane(0, 0, 0, 0, 1'b0, 1'b1);
        rif.branch_resolve = 1'b1;
        #1;
        check_eq("resolve_same_cycle", rif.rename_ready, 0);
        tick();
        idle();
        lane(0, 0, 0, 0, 1'b0, 1'b1);
        #1;
        check_eq("resolve_ready", rif.rename_ready, 1);
        check_eq("resolve_ckpt", rif.dispatch_ckpt_id, 0);
        check_eq("resolve_tag", tag_of(0), 7);
        tick();

        // Mispredict to a middle checkpoint
        idle();
        rif.branch_mispredict  = 1'b1;
        rif.mispredict_ckpt_id = 2'd2;
        tick();
        idle();
        lane(0, 8, 8, 0, 1'b1, 1'b0);
        lane(1, 0, 0, 0, 1'b0, 1'b1);
        #1;
        check_eq("mp2_map8", prs1_of(0), 8);
        check_eq("mp2_prd", prd_of(0), 33);
        check_eq("mp2_tag", tag_of(0), 4);
        check_eq("mp2_ckpt", rif.dispatch_ckpt_id, 3);
        check_eq("mp2_ready", rif.rename_ready, 1);
        tick();

        // Reset mid-operation
        do_reset();
        lane(0, 9, 9, 0, 1'b1, 1'b1);
        #1;
        check_eq("rst2_free_count", rif.free_count, 96);
        check_eq("rst2_ckpt", rif.dispatch_ckpt_id, 0);
        check_eq("rst2_prd", prd_of(0), 32);
        check_eq("rst2_tag", tag_of(0), 0);
        check_eq("rst2_prs1", prs1_of(0), 9);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
